// File: rtl/chacha_reg_pkg.sv
// Shared constants for the chacha register-bus master: register map,
// status/control encodings, write-sequence slot layout and the FSM state type.
package chacha_reg_pkg;

    localparam logic [7:0] ADDR_CONTROL = 8'h0a;
    localparam logic [7:0] ADDR_STATUS  = 8'h0b;
    localparam logic [7:0] ADDR_KEYLEN  = 8'h0c;
    localparam logic [7:0] ADDR_ROUNDS  = 8'h0d;
    localparam logic [7:0] ADDR_KEY0    = 8'h30;
    localparam logic [7:0] ADDR_NONCE0  = 8'h38;
    localparam logic [7:0] ADDR_INPUT0  = 8'h50;
    localparam logic [7:0] ADDR_OUTPUT0 = 8'h70;

    localparam int          STATUS_READY_BIT = 0;
    localparam logic [31:0] CTRL_INIT        = 32'h1;

    // Slot numbers of the 31-entry write sequence.
    localparam logic [4:0] SLOT_NONCE    = 5'd8;
    localparam logic [4:0] SLOT_ROUNDS   = 5'd11;
    localparam logic [4:0] SLOT_KEYLEN   = 5'd12;
    localparam logic [4:0] SLOT_INPUT    = 5'd13;
    localparam logic [4:0] SLOT_CTRL_SET = 5'd29;
    localparam logic [4:0] SLOT_CTRL_CLR = 5'd30;
    localparam logic [4:0] LAST_OUT_IDX  = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_SETTLE,
        ST_POLL_RD,
        ST_POLL_CHK,
        ST_OUT_RD,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_wr_t;

    // Address and payload of write slot idx; most significant word goes first.
    function automatic bus_wr_t write_slot(
        input logic [4:0]   idx,
        input logic [255:0] key,
        input logic [95:0]  nonce,
        input logic [4:0]   rounds,
        input logic         keylen,
        input logic [511:0] data
    );
        bus_wr_t w;
        w.addr = 8'h00;
        w.data = 32'h0;
        if (idx < SLOT_NONCE) begin
            w.addr = ADDR_KEY0 + 8'(idx);
            w.data = key[32*(7 - int'(idx)) +: 32];
        end else if (idx < SLOT_ROUNDS) begin
            w.addr = ADDR_NONCE0 + 8'(idx - SLOT_NONCE);
            w.data = nonce[32*(10 - int'(idx)) +: 32];
        end else if (idx == SLOT_ROUNDS) begin
            w.addr = ADDR_ROUNDS;
            w.data = {27'd0, rounds};
        end else if (idx == SLOT_KEYLEN) begin
            w.addr = ADDR_KEYLEN;
            w.data = {31'd0, keylen};
        end else if (idx < SLOT_CTRL_SET) begin
            w.addr = ADDR_INPUT0 + 8'(idx - SLOT_INPUT);
            w.data = data[32*(28 - int'(idx)) +: 32];
        end else if (idx == SLOT_CTRL_SET) begin
            w.addr = ADDR_CONTROL;
            w.data = CTRL_INIT;
        end else if (idx == SLOT_CTRL_CLR) begin
            w.addr = ADDR_CONTROL;
            w.data = 32'h0;
        end
        return w;
    endfunction

endpackage

// File: rtl/chacha_reg_master.sv
// Register-bus initiator for the chacha core: programs one job, polls status,
// reads the 16 output words back. Optional poll timeout: CHACHA_MASTER_TIMEOUT_EN.
module chacha_reg_master
    import chacha_reg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int POLL_TIMEOUT  = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [255:0] req_key,
    input  logic [95:0]  req_nonce,
    input  logic [4:0]   req_rounds,
    input  logic         req_keylen,
    input  logic [511:0] req_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [511:0] res_data,
    output logic         busy,
    output logic         timeout_err,
    output logic         cs,
    output logic         we,
    output logic [7:0]   addr,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both 1; res_valid/res_data hold until taken, req_ready only in IDLE.

    state_t         state, state_next;
    logic [4:0]     idx;
    logic [15:0]    settle_cnt;
    logic [255:0]   key_q;
    logic [95:0]    nonce_q;
    logic [4:0]     rounds_q;
    logic           keylen_q;
    logic [511:0]   data_q;
    logic [511:0]   res_q;
    logic           accept;
    logic           status_ready;
    logic           timeout_hit;
    bus_wr_t        wr_slot;

    assign accept       = (state == ST_IDLE) && req_valid;
    assign status_ready = read_data[STATUS_READY_BIT];
    assign busy         = (state != ST_IDLE);
    assign res_data     = res_q;

`ifdef CHACHA_MASTER_TIMEOUT_EN
    logic [12:0] poll_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
        end else if (accept) begin
            poll_cnt <= '0;
        end else if (state == ST_POLL_CHK && !status_ready) begin
            poll_cnt <= poll_cnt + 13'd1;
        end
    end

    assign timeout_hit = (state == ST_POLL_CHK) && !status_ready &&
                         (poll_cnt == 13'(POLL_TIMEOUT - 1));
`else
    logic [31:0] unused_poll_timeout;
    assign unused_poll_timeout = 32'(POLL_TIMEOUT);
    assign timeout_hit         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cs          = 1'b0;
        we          = 1'b0;
        addr        = 8'h00;
        write_data  = 32'h0;
        req_ready   = 1'b0;
        res_valid   = 1'b0;
        timeout_err = 1'b0;
        wr_slot     = write_slot(idx, key_q, nonce_q, rounds_q, keylen_q, data_q);
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_WR;
            end
            ST_WR: begin
                cs         = 1'b1;
                we         = 1'b1;
                addr       = wr_slot.addr;
                write_data = wr_slot.data;
                if (idx == SLOT_CTRL_CLR) begin
                    state_next = (SETTLE_CYCLES == 0) ? ST_POLL_RD : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 16'(SETTLE_CYCLES - 1)) state_next = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                cs         = 1'b1;
                addr       = ADDR_STATUS;
                state_next = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                // read_data here is the registered response to the previous cycle's read.
                if (status_ready) begin
                    state_next = ST_OUT_RD;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    state_next = ST_POLL_RD;
                end
            end
            ST_OUT_RD: begin
                if (idx != LAST_OUT_IDX) begin
                    cs   = 1'b1;
                    addr = ADDR_OUTPUT0 + {4'd0, idx[3:0]};
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            key_q      <= '0;
            nonce_q    <= '0;
            rounds_q   <= '0;
            keylen_q   <= 1'b0;
            data_q     <= '0;
            res_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        key_q      <= req_key;
                        nonce_q    <= req_nonce;
                        rounds_q   <= req_rounds;
                        keylen_q   <= req_keylen;
                        data_q     <= req_data;
                        idx        <= '0;
                        settle_cnt <= '0;
                    end
                end
                ST_WR: begin
                    idx <= (idx == SLOT_CTRL_CLR) ? 5'd0 : idx + 5'd1;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 16'd1;
                end
                ST_POLL_CHK: begin
                    idx <= '0;
                end
                ST_OUT_RD: begin
                    // Word read at idx-1 arrives now; shifting puts OUTPUT0 at the top.
                    if (idx != 5'd0) res_q <= {res_q[479:0], read_data};
                    idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/chacha_reg_master.md
Name: chacha_reg_master

Overview:
- Hardware host for the chacha register interface. It is the initiator side of the cs/we/addr/write_data/read_data bus that the chacha top responds on.
- Takes one complete job through a valid/ready request port: key, nonce, rounds, keylen and a 512-bit data block.
- Programs the registers, pulses control, polls status until ready, reads back the 16 output words, and returns them through a valid/ready result port.
- Replaces software or bench-driven register sequencing in SoC integration.

Parameters:
- SETTLE_CYCLES, 2, idle cycles after the control clear-write before the first status poll.
- POLL_TIMEOUT, 4096, maximum number of status polls before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  master can accept a job
- req_key  in  256  key; [255:224] goes to KEY0
- req_nonce  in  96  nonce; [95:64] goes to NONCE0
- req_rounds  in  5  round count
- req_keylen  in  1  key length select
- req_data  in  512  input block; [511:480] goes to INPUT0
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  512  output block; OUTPUT0 lands in [511:480]
- busy  out  1  job in progress (any state except IDLE)
- timeout_err  out  1  one-cycle pulse on poll timeout
- cs  out  1  bus select
- we  out  1  1 = write, 0 = read
- addr  out  8  register address
- write_data  out  32  write payload
- read_data  in  32  responder read data, registered (valid the cycle after the read strobe)

Behaviour:
- Reset: async on reset_n low. Forces IDLE and clears all registers. All outputs are 0 except req_ready, which is 1. The bus goes idle immediately, mid-transfer included; no partial job resumes.
- When cs=0, outputs are we=0, addr=0x00, write_data=0.
- Accept: a job is accepted on req_valid & req_ready in IDLE. All request fields are registered. req_ready is 0 in every other state.
- Write sequence, one write per cycle, cs=1, we=1, starting the cycle after accept:
  - KEY 0x30..0x37
  - NONCE 0x38..0x3a
  - ROUNDS 0x0d (zero-extended)
  - KEYLEN 0x0c (zero-extended)
  - INPUT 0x50..0x5f, word i at 0x50+i
  - CONTROL 0x0a = 0x00000001, then CONTROL 0x0a = 0x00000000
  - Total 31 consecutive bus cycles.
- FSM states:
  - IDLE → WR (31 writes, 5-bit index counter) → SETTLE (SETTLE_CYCLES, cs=0) → POLL_RD → POLL_CHK.
  - POLL_RD: read of 0x0b.
  - POLL_CHK: cs=0; sample read_data[0]. If 1 go to OUT_RD, else back to POLL_RD. Each poll takes 2 cycles.
  - OUT_RD: 16 back-to-back reads 0x70..0x7f. The word read in cycle n is captured in cycle n+1. 17 cycles total, the last with cs=0.
  - DONE: res_valid=1.
- Result handshake:
  - res_data stays stable while res_valid & !res_ready.
  - res_valid & res_ready returns to IDLE; req_ready=1 the following cycle.
  - A pending request while DONE waits. No overlap of jobs.
- Minimum latency, accept to res_valid: 31 + SETTLE_CYCLES + 2 + 17 cycles.
- The master never reads 0x70..0x7f before it has sampled status bit0=1.

Optional Feature:
- Macro: CHACHA_MASTER_TIMEOUT_EN.
- Defined:
  - A 13-bit poll counter increments per POLL_CHK that samples 0.
  - On reaching POLL_TIMEOUT: timeout_err pulses for 1 cycle and the FSM returns to IDLE with no res_valid.
  - The counter clears on accept.
- Undefined:
  - Polling is unbounded.
  - timeout_err is tied to 0 and no counter logic exists.

Decomposition:
- Package chacha_reg_pkg holds:
  - address constants ADDR_CONTROL/STATUS/KEYLEN/ROUNDS, ADDR_KEY0, ADDR_NONCE0, ADDR_INPUT0, ADDR_OUTPUT0
  - STATUS_READY_BIT = 0
  - CTRL_INIT = 32'h1
  - the FSM state enum
- No sub-module. A single FSM with a write index counter and a mux selecting addr/write_data is the natural structure.

Test Plan:
- Responder model. Key 000102..1f, nonce 000000090000004a00000000, rounds 20, keylen 1, data all zero.
  - Bus trace starts with (0x30, 0x00010203) and ends the write phase with (0x0a,1), (0x0a,0).
  - 31 writes, consecutive.
- Responder status=0 for 10 polls, then 1.
  - Exactly 11 reads of 0x0b.
  - First 0x70 read follows the ready sample.
  - res_data equals the model's 16 words in order.
- res_ready held 0 for 5 cycles after res_valid.
  - res_data stable, req_ready=0, no bus activity.
  - Accepted on the 6th cycle, req_ready=1 the next cycle.
- reset_n low during the write to 0x54.
  - cs=0 in the same timestep.
  - After release: IDLE, req_ready=1, res_valid=0.
  - A new job then runs a clean full sequence.
- With CHACHA_MASTER_TIMEOUT_EN and POLL_TIMEOUT=16, status stuck at 0.
  - timeout_err pulses once after the 16th poll.
  - No 0x70 reads, res_valid stays 0, req_ready returns to 1.
